// File: rtl/ub_read_sequencer.sv
// Unified-buffer read sequencer: walks a strided block of buffer rows, one read
// per cycle, and streams the returned rows out through a small credit-managed
// FIFO with full valid/ready backpressure.

package tpu_package;
  localparam int MUL_SIZE  = 4;
  localparam int ACT_WIDTH = 7;
endpackage

module ub_read_sequencer
  import tpu_package::*;
#(
  parameter int ADDR_W     = 12,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             cmd_valid_i,
  output logic                             cmd_ready_o,
  input  logic [ADDR_W-1:0]                cmd_base_i,
  input  logic [ADDR_W:0]                  cmd_rows_i,
  input  logic [ADDR_W-1:0]                cmd_stride_i,
  output logic                             ub_read_o,
  output logic [ADDR_W-1:0]                ub_addr_rd_o,
  input  logic [MUL_SIZE-1:0][ACT_WIDTH:0] ub_data_i,
  output logic                             row_valid_o,
  input  logic                             row_ready_i,
  output logic [MUL_SIZE-1:0][ACT_WIDTH:0] row_data_o,
  output logic                             row_last_o,
  output logic                             busy_o,
  output logic                             done_o
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                           r_state;
  logic [ADDR_W-1:0]                r_issue_addr;
  logic [ADDR_W:0]                  r_issue_rem;
  logic [ADDR_W:0]                  r_deliv_rem;
  logic                             r_cmd_ready;
  logic                             r_busy;
  logic                             r_done;

  logic                             r_vld_p1;

  logic [MUL_SIZE-1:0][ACT_WIDTH:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]                 r_wptr;
  logic [PTR_W-1:0]                 r_rptr;
  logic [CNT_W-1:0]                 r_count;

  logic                             w_cmd_fire;
  logic                             w_pop;
  logic                             w_push;
  logic                             w_issue;
  logic                             w_credit_ok;
  logic [CNT_W:0]                   w_occ;

  function automatic logic [PTR_W-1:0] f_ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(FIFO_DEPTH - 1)) begin
      return '0;
    end
    return p + 1'b1;
  endfunction

  assign w_cmd_fire = (r_state == S_IDLE) && r_cmd_ready && cmd_valid_i;
  assign w_pop      = row_valid_o && row_ready_i;
  assign w_push     = r_vld_p1;

  // Slots already claimed (stored rows plus the read whose data lands this
  // cycle), less the row leaving this cycle. Counting the pop in the same
  // cycle is what lets a 2-entry FIFO sustain one row per cycle.
  assign w_occ       = {1'b0, r_count} + {{CNT_W{1'b0}}, r_vld_p1}
                       - {{CNT_W{1'b0}}, w_pop};
  assign w_credit_ok = (w_occ < (CNT_W + 1)'(FIFO_DEPTH));

  // The read strobe must react to a same-cycle pop, so it is decoded from the
  // state and counters rather than registered; the address comes straight
  // from the issue-address register.
  assign w_issue      = (r_state == S_ISSUE) && (r_issue_rem != '0) && w_credit_ok;
  assign ub_read_o    = w_issue;
  assign ub_addr_rd_o = r_issue_addr;

  assign cmd_ready_o = r_cmd_ready;
  assign busy_o      = r_busy;
  assign done_o      = r_done;

  assign row_valid_o = (r_count != '0);
  assign row_data_o  = row_valid_o ? r_mem[r_rptr] : '0;
  assign row_last_o  = row_valid_o && (r_deliv_rem == (ADDR_W + 1)'(1));

  // Command sequencing: accept, issue reads under credit, drain, pulse done.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state      <= S_IDLE;
      r_issue_addr <= '0;
      r_issue_rem  <= '0;
      r_deliv_rem  <= '0;
      r_cmd_ready  <= 1'b1;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_cmd_fire) begin
            r_issue_addr <= cmd_base_i;
            r_issue_rem  <= cmd_rows_i;
            r_deliv_rem  <= cmd_rows_i;
            r_cmd_ready  <= 1'b0;
            r_busy       <= 1'b1;
            r_state      <= (cmd_rows_i == '0) ? S_DONE : S_ISSUE;
          end else begin
            // Ready reopens the cycle after the done pulse.
            r_cmd_ready <= 1'b1;
          end
        end
        S_ISSUE: begin
          if (w_issue) begin
            r_issue_addr <= r_issue_addr + cmd_stride_q();
            r_issue_rem  <= r_issue_rem - 1'b1;
            if (r_issue_rem == (ADDR_W + 1)'(1)) begin
              r_state <= S_DRAIN;
            end
          end
          if (w_pop) begin
            r_deliv_rem <= r_deliv_rem - 1'b1;
          end
        end
        S_DRAIN: begin
          if (w_pop) begin
            r_deliv_rem <= r_deliv_rem - 1'b1;
          end
          if (r_deliv_rem == '0) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Stride is captured with the command so later changes on the port are ignored.
  logic [ADDR_W-1:0] r_stride;

  function automatic logic [ADDR_W-1:0] cmd_stride_q();
    return r_stride;
  endfunction

  // Latch the stride at the command handshake.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_stride <= '0;
    end else if (w_cmd_fire) begin
      r_stride <= cmd_stride_i;
    end
  end

  // ---- stage p1: buffer read in flight, data on ub_data_i this cycle ----
  // Track the outstanding read; cleared by reset so stale returns are dropped.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_vld_p1 <= 1'b0;
    end else begin
      r_vld_p1 <= w_issue;
    end
  end

  // ---- stage p2: returned row captured in the output FIFO ----
  // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= f_ptr_inc(r_wptr);
      end
      if (w_pop) begin
        r_rptr <= f_ptr_inc(r_rptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO row storage; contents are only visible while the entry is valid.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wptr] <= ub_data_i;
    end
  end

endmodule
